pipeline_step_ctrl: RTL and testbench

- Execution controller that generates the i_enable inputs of the PC register and the pipeline latch registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the MIPS core.
- Supports four modes: continuous run, single-cycle step, pause, and halt with pipeline drain.
- Commands come from the debug unit; halt detection comes from decode; stall requests come from the hazard unit.
- Also counts executed cycles for debug readout.

---
 rtl/pipeline_step_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_step_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_step_ctrl.sv
// Execution controller for the MIPS core: generates the PC, IF/ID and
// back-pipeline enables for continuous run, single step, pause and
// halt-with-drain, and counts executed (pipe-enabled) cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | paused, all enables low, waiting for run/step
// ST_RUN    | free running until stop or a decoded HALT
// ST_STEP   | one active cycle, then back to IDLE (or DRAIN on HALT)
// ST_DRAIN  | front end frozen, back pipeline runs DRAIN_CYCLES cycles
// ST_HALTED | sticky stop after drain, only reset leaves it
module pipeline_step_ctrl #(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_DRAIN     = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_stop,
  input  logic              i_halt_instr,
  input  logic              i_hazard_stall,
  output logic              o_pc_enable,
  output logic              o_if_id_enable,
  output logic              o_pipe_enable,
  output logic              o_running,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(1);
  localparam logic [NB_CNT-1:0]   CNT_MAX    = {NB_CNT{1'b1}};

  logic [2:0]          state_q, state_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                active;
  logic                front_en;

  // Output decode from registered state; the stall only freezes the front end.
  always_comb begin
    active         = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    front_en       = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !i_hazard_stall;
    o_pipe_enable  = active;
    o_pc_enable    = front_en;
    o_if_id_enable = front_en;
    o_running      = (state_q == ST_RUN);
    o_halted       = (state_q == ST_HALTED);
    o_cycle_count  = cnt_q;
  end

  // Next-state logic and drain down-counter; DRAIN ends when the count hits 1.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (i_halt_instr) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (i_stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_halt_instr) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRAIN_LAST;
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Executed-cycle counter, saturating so a long run never reads back as small.
  always_comb begin
    cnt_d = cnt_q;
    if (active && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  // State, drain counter and cycle counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl: a table of per-cycle vectors
// plus hand-written sequences for counter saturation and mid-flight reset.
module tb_pipeline_step_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_run, i_step, i_stop, i_halt_instr, i_hazard_stall;
  logic        pc_en, ifid_en, pipe_en, running, halted;
  logic [31:0] cnt;
  logic        s_pc_en, s_ifid_en, s_pipe_en, s_running, s_halted;
  logic [3:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  pipeline_step_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_stop(i_stop), .i_halt_instr(i_halt_instr), .i_hazard_stall(i_hazard_stall),
    .o_pc_enable(pc_en), .o_if_id_enable(ifid_en), .o_pipe_enable(pipe_en),
    .o_running(running), .o_halted(halted), .o_cycle_count(cnt)
  );

  pipeline_step_ctrl #(.NB_CNT(4)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_stop(i_stop), .i_halt_instr(i_halt_instr), .i_hazard_stall(i_hazard_stall),
    .o_pc_enable(s_pc_en), .o_if_id_enable(s_ifid_en), .o_pipe_enable(s_pipe_en),
    .o_running(s_running), .o_halted(s_halted), .o_cycle_count(s_cnt)
  );

  typedef struct {
    logic        run, step, stop, halt, stall, rst;
    logic        pc, ifid, pipe, rn, hl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic v(input logic run, step, stop, halt, stall, rst,
                   input logic pc, ifid, pipe, rn, hl, input int c);
    vec_t x;
    x.run = run; x.step = step; x.stop = stop; x.halt = halt; x.stall = stall; x.rst = rst;
    x.pc = pc; x.ifid = ifid; x.pipe = pipe; x.rn = rn; x.hl = hl; x.cnt = 32'(c);
    tbl.push_back(x);
  endtask

  task automatic drive(input logic run, step, stop, halt, stall, rst);
    i_run = run; i_step = step; i_stop = stop;
    i_halt_instr = halt; i_hazard_stall = stall; i_reset = rst;
  endtask

  task automatic check_outs(input string tag, input logic pc, ifid, pipe, rn, hl,
                            input int c);
    chk({tag, " pc_en"},   32'(pc_en),   32'(pc));
    chk({tag, " ifid_en"}, 32'(ifid_en), 32'(ifid));
    chk({tag, " pipe_en"}, 32'(pipe_en), 32'(pipe));
    chk({tag, " running"}, 32'(running), 32'(rn));
    chk({tag, " halted"},  32'(halted),  32'(hl));
    chk({tag, " count"},   cnt,          32'(c));
  endtask

  initial begin
    // Each row: inputs for this cycle, outputs expected in this cycle
    // (count shows the cycles completed before it).
    // Test 1: single step.
    v(0,0,0,0,0,0, 0,0,0,0,0, 0);
    v(0,1,0,0,0,0, 0,0,0,0,0, 0);
    v(0,1,0,0,0,0, 1,1,1,0,0, 0);    // step during STEP is ignored
    v(0,0,0,0,0,0, 0,0,0,0,0, 1);
    v(0,0,0,0,0,1, 0,0,0,0,0, 1);
    // Test 2: run 10 cycles then stop.
    v(1,0,0,0,0,0, 0,0,0,0,0, 0);
    for (int k = 0; k < 10; k++) v(0,0,(k == 9),0,0,0, 1,1,1,1,0, k);
    v(0,0,0,0,0,0, 0,0,0,0,0, 10);
    v(0,0,0,0,0,1, 0,0,0,0,0, 10);
    // Test 3: hazard stall in RUN freezes only the front end.
    v(1,0,0,0,0,0, 0,0,0,0,0, 0);
    v(0,0,0,0,0,0, 1,1,1,1,0, 0);
    v(0,0,0,0,1,0, 0,0,1,1,0, 1);
    v(0,0,0,0,1,0, 0,0,1,1,0, 2);
    v(0,0,1,0,0,0, 1,1,1,1,0, 3);
    v(0,0,0,0,1,0, 0,0,0,0,0, 4);    // stall in IDLE changes nothing
    v(0,0,0,0,0,1, 0,0,0,0,0, 4);
    // Test 4: halt in RUN, drain, then sticky HALTED.
    v(1,0,0,1,0,0, 0,0,0,0,0, 0);    // halt ignored in IDLE
    v(0,0,0,0,0,0, 1,1,1,1,0, 0);
    v(0,0,0,1,0,0, 1,1,1,1,0, 1);
    v(0,1,0,0,0,0, 0,0,1,0,0, 2);
    v(0,0,1,0,1,0, 0,0,1,0,0, 3);
    v(1,0,0,0,0,0, 0,0,1,0,0, 4);
    v(0,0,0,1,0,0, 0,0,1,0,0, 5);
    v(1,0,0,0,0,0, 0,0,0,0,1, 6);
    v(0,1,0,0,0,0, 0,0,0,0,1, 6);
    v(0,0,0,0,0,0, 0,0,0,0,1, 6);
    v(0,0,0,0,0,1, 0,0,0,0,1, 6);
    // Test 5a: halt during STEP.
    v(0,1,0,0,0,0, 0,0,0,0,0, 0);
    v(1,0,0,1,0,0, 1,1,1,0,0, 0);
    for (int k = 1; k <= 4; k++) v(0,0,0,0,0,0, 0,0,1,0,0, k);
    v(0,0,0,0,0,0, 0,0,0,0,1, 5);
    v(0,0,0,0,0,1, 0,0,0,0,1, 5);
    // Test 5b: stop and halt together in RUN while stalled: halt wins.
    v(1,0,0,0,0,0, 0,0,0,0,0, 0);
    v(0,0,1,1,1,0, 0,0,1,1,0, 0);
    for (int k = 1; k <= 4; k++) v(0,0,0,0,0,0, 0,0,1,0,0, k);
    v(0,0,0,0,0,0, 0,0,0,0,1, 5);
    v(0,0,0,0,0,1, 0,0,0,0,1, 5);
    // Run has priority over step in IDLE.
    v(1,1,0,0,0,0, 0,0,0,0,0, 0);
    v(0,0,1,0,0,0, 1,1,1,1,0, 0);
    v(0,0,0,0,0,0, 0,0,0,0,0, 1);

    drive(0,0,0,0,0,1);
    @(negedge i_clk);
    @(negedge i_clk);

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].step, tbl[i].stop, tbl[i].halt, tbl[i].stall, tbl[i].rst);
      #1;
      check_outs($sformatf("row%0d", i), tbl[i].pc, tbl[i].ifid, tbl[i].pipe,
                 tbl[i].rn, tbl[i].hl, int'(tbl[i].cnt));
      @(negedge i_clk);
    end

    // Test 6: saturation of a 4-bit counter over a 20-cycle run.
    drive(0,0,0,0,0,1);
    @(negedge i_clk);
    drive(1,0,0,0,0,0);
    #1;
    chk("sat reset count", 32'(s_cnt), 32'd0);
    @(negedge i_clk);
    drive(0,0,0,0,0,0);
    repeat (19) @(negedge i_clk);
    drive(0,0,1,0,0,0);
    @(negedge i_clk);
    drive(0,0,0,0,0,0);
    #1;
    chk("sat count 4-bit", 32'(s_cnt), 32'd15);
    chk("sat count 32-bit", cnt, 32'd20);
    chk("sat running", 32'(s_running), 32'd0);

    // Reset mid-RUN with conflicting commands present.
    @(negedge i_clk);
    drive(1,0,0,0,0,0);
    @(negedge i_clk);
    drive(0,0,0,0,0,0);
    repeat (3) @(negedge i_clk);
    drive(1,0,0,1,0,1);
    @(negedge i_clk);
    drive(0,0,0,0,0,0);
    #1;
    check_outs("rst_run", 0, 0, 0, 0, 0, 0);

    // Reset mid-DRAIN.
    @(negedge i_clk);
    drive(1,0,0,0,0,0);
    @(negedge i_clk);
    drive(0,0,0,1,0,0);
    @(negedge i_clk);
    drive(0,0,0,0,0,0);
    #1;
    check_outs("drain1", 0, 0, 1, 0, 0, 1);
    @(negedge i_clk);
    drive(0,1,0,0,0,1);
    @(negedge i_clk);
    drive(0,0,0,0,0,0);
    #1;
    check_outs("rst_drain", 0, 0, 0, 0, 0, 0);
    chk("rst_drain sat count", 32'(s_cnt), 32'd0);
    chk("rst_drain sat halted", 32'(s_halted), 32'd0);
    @(negedge i_clk);
    #1;
    check_outs("after_rst", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
